// File: rtl/bsg_div_pkg.sv
// ---------------------------------------------------------------------------
// bsg_div_pkg
//
// Shared definitions for the sequential restoring divider.
//   bsg_div_state_e : controller states (IDLE, CALC, FIX, DONE).
//   ctr_width()     : width of the iteration counter for a given operand
//                     width. The counter has to reach width-1.
// ---------------------------------------------------------------------------
package bsg_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // waiting for operands, ready_o=1
    CALC = 2'd1,  // one quotient bit per cycle
    FIX  = 2'd2,  // sign restore and divide-by-zero override
    DONE = 2'd3   // result presented until the consumer takes it
  } bsg_div_state_e;

  // Counter width for `width` iterations (counts 0 .. width-1).
  // Floor of 1 so that a degenerate width still yields a legal vector.
  function automatic int ctr_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage : bsg_div_pkg

// File: rtl/bsg_div_seq_step.sv
// ---------------------------------------------------------------------------
// bsg_div_seq_step
//
// One combinational radix-2 restoring division iteration on unsigned
// magnitudes. The pair {rem, quo} is shifted left by one. The bit that
// leaves quo enters rem. A trial subtraction of the divisor then decides
// whether rem is replaced by the difference, and sets the new quotient
// LSB to match.
//
// Ports
//   rem         : partial remainder. Invariant: rem < divisor_mag
//                 whenever divisor_mag != 0.
//   quo         : partially shifted dividend / developing quotient.
//   divisor_mag : divisor magnitude.
//   next_rem    : partial remainder after this iteration.
//   next_quo    : quotient register after this iteration.
// ---------------------------------------------------------------------------
module bsg_div_seq_step #(
  parameter int width_p = 32
) (
  input  logic [width_p-1:0] rem,
  input  logic [width_p-1:0] quo,
  input  logic [width_p-1:0] divisor_mag,
  output logic [width_p-1:0] next_rem,
  output logic [width_p-1:0] next_quo
);

  // The shifted remainder needs one extra bit, because 2*rem+1 can reach
  // 2*divisor-1. Given the invariant, the true difference always lies in
  // (-2^width_p, 2^width_p). A width_p+1 bit two's-complement result is
  // therefore exact, and its MSB is the sign of the difference.
  logic [width_p:0] rem_shifted;
  logic [width_p:0] trial;
  logic             trial_neg;

  assign rem_shifted = {rem, quo[width_p-1]};
  assign trial       = rem_shifted - {1'b0, divisor_mag};
  assign trial_neg   = trial[width_p];

  // When the trial goes negative, rem_shifted is below the divisor, so its
  // top bit is zero. Dropping that bit is safe.
  assign next_rem = trial_neg ? rem_shifted[width_p-1:0] : trial[width_p-1:0];
  assign next_quo = {quo[width_p-2:0], ~trial_neg};

endmodule : bsg_div_seq_step

// File: rtl/bsg_div_seq.sv
// ---------------------------------------------------------------------------
// bsg_div_seq
//
// Sequential radix-2 restoring integer divider with an optional
// two's-complement mode selected per operation.
//   - Operands are accepted on v_i & ready_o.
//   - The block runs width_p iterations, one quotient bit per cycle.
//   - A single fix-up cycle follows.
//   - The result is then held on v_o until yumi_i.
//
// Ports
//   clock_i     : rising-edge clock.
//   reset_n_i   : synchronous, active-low reset.
//   v_i         : operands valid. Sampled only in IDLE.
//   ready_o     : block can accept operands (IDLE).
//   dividend_i  : dividend. Only needs to be stable in the acceptance cycle.
//   divisor_i   : divisor. Only needs to be stable in the acceptance cycle.
//   signed_i    : 1 = two's-complement operation, 0 = unsigned.
//   v_o         : result valid (DONE).
//   yumi_i      : consumer takes the result. Ignored unless v_o=1.
//   quotient_o  : quotient, truncated toward zero. All ones on divide by 0.
//   remainder_o : remainder with the dividend's sign. Equals the dividend
//                 on divide by 0.
//
// Latency: acceptance at edge E produces v_o=1 from edge E+width_p+1 on.
// The earliest following acceptance is width_p+3 edges after E.
// ---------------------------------------------------------------------------
module bsg_div_seq
  import bsg_div_pkg::*;
#(
  parameter int width_p = 32
) (
  input  logic               clock_i,
  input  logic               reset_n_i,

  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] dividend_i,
  input  logic [width_p-1:0] divisor_i,
  input  logic               signed_i,

  output logic               v_o,
  input  logic               yumi_i,
  output logic [width_p-1:0] quotient_o,
  output logic [width_p-1:0] remainder_o
);

  localparam int ctr_w_lp = ctr_width(width_p);
  localparam logic [ctr_w_lp-1:0] last_iter_lp = ctr_w_lp'(width_p - 1);

  // -------------------------------------------------------------------------
  // Controller
  // -------------------------------------------------------------------------
  bsg_div_state_e state_reg, state_next;

  logic [ctr_w_lp-1:0] count_reg;
  logic                last_iter;

  assign last_iter = (count_reg == last_iter_lp);

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (v_i)       state_next = CALC;
      CALC:    if (last_iter) state_next = FIX;
      FIX:                    state_next = DONE;
      DONE:    if (yumi_i)    state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // Both handshake outputs decode the state register only. This keeps
  // them free of any combinational path from the inputs.
  assign ready_o = (state_reg == IDLE);
  assign v_o     = (state_reg == DONE);

  // -------------------------------------------------------------------------
  // Operand conditioning (acceptance cycle only)
  // -------------------------------------------------------------------------
  logic dividend_sign, divisor_sign;
  logic [width_p-1:0] dividend_mag, divisor_mag_in;

  assign dividend_sign = signed_i & dividend_i[width_p-1];
  assign divisor_sign  = signed_i & divisor_i[width_p-1];

  // The negation of MIN wraps back to MIN. Read as unsigned, that is
  // exactly |MIN|, so MIN / -1 needs no special handling downstream.
  assign dividend_mag   = dividend_sign ? (~dividend_i + 1'b1) : dividend_i;
  assign divisor_mag_in = divisor_sign  ? (~divisor_i  + 1'b1) : divisor_i;

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  logic [width_p-1:0] rem_reg;
  logic [width_p-1:0] quo_reg;
  logic [width_p-1:0] div_mag_reg;
  logic [width_p-1:0] dividend_reg;  // raw dividend for divide-by-zero
  logic               quo_neg_reg;
  logic               rem_neg_reg;
  logic               zero_reg;

  logic [width_p-1:0] step_rem, step_quo;

  bsg_div_seq_step #(
    .width_p(width_p)
  ) step (
    .rem        (rem_reg),
    .quo        (quo_reg),
    .divisor_mag(div_mag_reg),
    .next_rem   (step_rem),
    .next_quo   (step_quo)
  );

  // -------------------------------------------------------------------------
  // Fix-up: restore signs, then let divide-by-zero override everything
  // -------------------------------------------------------------------------
  logic [width_p-1:0] fix_quo, fix_rem;

  always_comb begin
    fix_quo = quo_neg_reg ? (~quo_reg + 1'b1) : quo_reg;
    fix_rem = rem_neg_reg ? (~rem_reg + 1'b1) : rem_reg;
    if (zero_reg) begin
      fix_quo = '1;
      fix_rem = dividend_reg;
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      count_reg    <= '0;
      rem_reg      <= '0;
      quo_reg      <= '0;
      div_mag_reg  <= '0;
      dividend_reg <= '0;
      quo_neg_reg  <= 1'b0;
      rem_neg_reg  <= 1'b0;
      zero_reg     <= 1'b0;
      quotient_o   <= '0;
      remainder_o  <= '0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (v_i) begin
            // Restoring division starts with an empty remainder. The
            // dividend magnitude shifts into it from the quotient side.
            rem_reg      <= '0;
            quo_reg      <= dividend_mag;
            div_mag_reg  <= divisor_mag_in;
            dividend_reg <= dividend_i;
            quo_neg_reg  <= dividend_sign ^ divisor_sign;
            rem_neg_reg  <= dividend_sign;
            zero_reg     <= (divisor_i == '0);
            count_reg    <= '0;
          end
        end
        CALC: begin
          rem_reg   <= step_rem;
          quo_reg   <= step_quo;
          count_reg <= count_reg + 1'b1;
        end
        FIX: begin
          quotient_o  <= fix_quo;
          remainder_o <= fix_rem;
        end
        default: begin
          // DONE: outputs hold until the consumer takes them.
        end
      endcase
    end
  end

endmodule : bsg_div_seq

// File: tb/tb_bsg_div_seq.sv
// ---------------------------------------------------------------------------
// tb_bsg_div_seq
//
// Directed and randomized checks of bsg_div_seq at width_p=32. Expected
// results come from the arithmetic definition of truncating division,
// evaluated on 64-bit integers, plus the divide-by-zero rule.
// ---------------------------------------------------------------------------
module tb_bsg_div_seq;

  localparam int W      = 32;
  localparam int LAT    = W + 2;  // acceptance cycle -> first cycle with v_o
  localparam int BUDGET = 200;

  logic         clock_i = 1'b0;
  logic         reset_n_i;
  logic         v_i;
  logic         ready_o;
  logic [W-1:0] dividend_i;
  logic [W-1:0] divisor_i;
  logic         signed_i;
  logic         v_o;
  logic         yumi_i;
  logic [W-1:0] quotient_o;
  logic [W-1:0] remainder_o;

  int n_checks = 0;
  int n_fail   = 0;

  bsg_div_seq #(.width_p(W)) dut (
    .clock_i    (clock_i),
    .reset_n_i  (reset_n_i),
    .v_i        (v_i),
    .ready_o    (ready_o),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .signed_i   (signed_i),
    .v_o        (v_o),
    .yumi_i     (yumi_i),
    .quotient_o (quotient_o),
    .remainder_o(remainder_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  // Reference: truncating division on 64-bit integers. Signed operands are
  // sign-extended, so MIN / -1 = +2^31, which truncates to MIN in 32 bits.
  function automatic logic [2*W-1:0] ref_div(input logic [W-1:0] a,
                                              input logic [W-1:0] b,
                                              input logic s);
    longint sa, sb, q, r;
    logic [63:0] qv, rv;
    if (b == '0) return {{W{1'b1}}, a};
    sa = s ? longint'($signed(a)) : longint'({32'h0, a});
    sb = s ? longint'($signed(b)) : longint'({32'h0, b});
    q  = sa / sb;
    r  = sa % sb;
    qv = q;
    rv = r;
    return {qv[W-1:0], rv[W-1:0]};
  endfunction

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  // Present operands for one cycle once ready_o is high. Afterwards the
  // inputs are scrambled: they only have to be valid at acceptance.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    int w = 0;
    while (!ready_o && w < BUDGET) begin
      tick();
      w++;
    end
    check("ready_before_issue", W'(ready_o), W'(1));
    dividend_i = a;
    divisor_i  = b;
    signed_i   = s;
    v_i        = 1'b1;
    tick();
    v_i        = 1'b0;
    dividend_i = $urandom;
    divisor_i  = $urandom;
    signed_i   = 1'($urandom_range(0, 1));
  endtask

  // Counts cycles from the acceptance cycle (cycle 0) up to the first
  // cycle in which v_o is seen.
  task automatic wait_result(output int cyc);
    cyc = 1;
    while (!v_o && cyc < BUDGET) begin
      tick();
      cyc++;
    end
  endtask

  task automatic consume();
    yumi_i = 1'b1;
    tick();
    yumi_i = 1'b0;
    check("ready_after_yumi", W'(ready_o), W'(1));
    check("v_o_after_yumi", W'(v_o), W'(0));
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic [W-1:0] eq, input logic [W-1:0] er);
    int cyc;
    start_op(a, b, s);
    wait_result(cyc);
    $display("op %s a=0x%h b=0x%h s=%0d -> q=0x%h r=0x%h latency=%0d",
             tag, a, b, s, quotient_o, remainder_o, cyc);
    check({tag, "_latency"}, W'(cyc), W'(LAT));
    check({tag, "_quotient"}, quotient_o, eq);
    check({tag, "_remainder"}, remainder_o, er);
    consume();
  endtask

  initial begin
    logic [2*W-1:0] m;
    logic [W-1:0]   hq, hr, ra, rb;
    logic           rs;
    int             cyc;

    reset_n_i  = 1'b0;
    v_i        = 1'b0;
    yumi_i     = 1'b0;
    dividend_i = '0;
    divisor_i  = '0;
    signed_i   = 1'b0;
    tick();
    tick();
    check("reset_ready", W'(ready_o), W'(1));
    check("reset_v_o", W'(v_o), W'(0));
    check("reset_quotient", quotient_o, '0);
    check("reset_remainder", remainder_o, '0);
    reset_n_i = 1'b1;
    tick();

    // Directed vectors with hand-derived expectations.
    run_op("u100_7",     32'd100,        32'd7,          1'b0, 32'd14,         32'd2);
    run_op("s-100_7",    32'hFFFFFF9C,   32'd7,          1'b1, 32'hFFFFFFF2,   32'hFFFFFFFE);
    run_op("s100_-7",    32'd100,        32'hFFFFFFF9,   1'b1, 32'hFFFFFFF2,   32'd2);
    run_op("u_div0",     32'h1234,       32'd0,          1'b0, 32'hFFFFFFFF,   32'h1234);
    run_op("s_div0",     32'hFFFFFF9C,   32'd0,          1'b1, 32'hFFFFFFFF,   32'hFFFFFF9C);
    run_op("s_overflow", 32'h80000000,   32'hFFFFFFFF,   1'b1, 32'h80000000,   32'd0);
    run_op("u_max_1",    32'hFFFFFFFF,   32'd1,          1'b0, 32'hFFFFFFFF,   32'd0);
    run_op("s-7_-2",     32'hFFFFFFF9,   32'hFFFFFFFE,   1'b1, 32'd3,          32'hFFFFFFFF);

    // Back-pressure: hold the result for 5 cycles while poking v_i.
    start_op(32'd1000, 32'd33, 1'b0);
    wait_result(cyc);
    check("bp_latency", W'(cyc), W'(LAT));
    hq = quotient_o;
    hr = remainder_o;
    check("bp_quotient", hq, 32'd30);
    check("bp_remainder", hr, 32'd10);
    for (int i = 0; i < 5; i++) begin
      v_i        = 1'b1;
      dividend_i = $urandom;
      divisor_i  = $urandom;
      tick();
      check("bp_v_o_held", W'(v_o), W'(1));
      check("bp_ready_low", W'(ready_o), W'(0));
      check("bp_quotient_held", quotient_o, hq);
      check("bp_remainder_held", remainder_o, hr);
    end
    v_i = 1'b0;
    $display("op backpressure held 5 cycles q=0x%h r=0x%h", quotient_o, remainder_o);
    consume();
    // Immediate follow-on request in the first ready cycle.
    run_op("u200_9", 32'd200, 32'd9, 1'b0, 32'd22, 32'd2);

    // Reset in the 10th CALC cycle aborts the operation.
    start_op(32'd123456, 32'd7, 1'b0);
    repeat (9) tick();
    reset_n_i = 1'b0;
    tick();
    reset_n_i = 1'b1;
    $display("op reset_mid_calc ready=%0d v_o=%0d q=0x%h r=0x%h",
             ready_o, v_o, quotient_o, remainder_o);
    check("midrst_ready", W'(ready_o), W'(1));
    check("midrst_v_o", W'(v_o), W'(0));
    check("midrst_quotient", quotient_o, '0);
    check("midrst_remainder", remainder_o, '0);
    run_op("u9_3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0);

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      int mode;
      ra   = $urandom;
      rs   = 1'($urandom_range(0, 1));
      mode = $urandom_range(0, 9);
      if (mode == 0) rb = '0;
      else if (mode <= 4) begin
        rb = W'($urandom_range(1, 15));
        if (rs && $urandom_range(0, 1) == 1) rb = -rb;
      end else rb = $urandom >> $urandom_range(0, 28);
      if (mode == 9) ra = 32'h80000000;
      m = ref_div(ra, rb, rs);
      run_op("rand", ra, rb, rs, m[2*W-1:W], m[W-1:0]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_bsg_div_seq
